// File: rtl/regfile_dump_engine_if.sv
// Bus bundle between the register-file dump engine and its environment:
// control, register-file read port A and the valid/ready output stream.
interface regfile_dump_engine_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
);
  logic                  start;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] first_addr;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [ADDR_WIDTH-1:0] rdAddr;
  logic [DATA_WIDTH-1:0] rdData;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, abort, first_addr, last_addr, rdData, out_ready,
    output rdAddr, out_data, out_addr, out_valid, busy, done
  );

  modport slave (
    output start, abort, first_addr, last_addr, rdData, out_ready,
    input  rdAddr, out_data, out_addr, out_valid, busy, done
  );
endinterface

// File: rtl/regfile_dump_engine.sv
// Walks a wrapping address range on register-file read port A and streams
// each value with its address over a valid/ready output, one word per cycle.
module regfile_dump_engine #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_dump_engine_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic                  r_out_valid;
  logic                  r_done;
  logic                  w_load;
  logic                  w_capture;
  logic                  w_flush;
  logic                  w_finish;

  // Modulo-2^ADDR_WIDTH span plus one, so first == last+1 yields a full sweep.
  function automatic logic [ADDR_WIDTH:0] word_count(
    input logic [ADDR_WIDTH-1:0] first,
    input logic [ADDR_WIDTH-1:0] last
  );
    logic [ADDR_WIDTH-1:0] span;
    span = last - first;
    return {1'b0, span} + CNT_ONE;
  endfunction

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_capture = 1'b0;
    w_flush   = 1'b0;
    w_finish  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_load = 1'b1;
          w_next = S_READ;
        end
      end
      S_READ: begin
        // Abort wins over both capture and the accept of the held word.
        if (bus.abort) begin
          w_flush = 1'b1;
          w_next  = S_IDLE;
        end else if (!r_out_valid || bus.out_ready) begin
          w_capture = 1'b1;
          if (r_remaining == CNT_ONE) w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.abort) begin
          w_flush = 1'b1;
          w_next  = S_IDLE;
        end else if (r_out_valid && bus.out_ready) begin
          w_finish = 1'b1;
          w_next   = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_remaining <= '0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_finish;
      if (w_load) begin
        r_ptr       <= bus.first_addr;
        r_remaining <= word_count(bus.first_addr, bus.last_addr);
      end
      // rdData is sampled before any same-edge write lands, giving the old value.
      if (w_capture) begin
        r_out_data  <= bus.rdData;
        r_out_addr  <= r_ptr;
        r_out_valid <= 1'b1;
        r_ptr       <= r_ptr + PTR_ONE;
        r_remaining <= r_remaining - CNT_ONE;
      end
      if (w_flush || w_finish) r_out_valid <= 1'b0;
    end
  end

  assign bus.rdAddr    = r_ptr;
  assign bus.out_data  = r_out_data;
  assign bus.out_addr  = r_out_addr;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;

endmodule

// File: tb/tb_regfile_dump_engine.sv
// Scoreboard bench for regfile_dump_engine: a register-array model supplies
// read data and expected words; a negedge monitor checks every accepted word.
module tb_regfile_dump_engine;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  regfile_dump_engine_if #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) bus ();

  regfile_dump_engine #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [63:0] regs [32];
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  always @(posedge clk) if (wr_en) regs[wr_addr] <= wr_data;
  assign bus.rdData = regs[bus.rdAddr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  addr;
    logic [63:0] data;
    bit          last;
    int          ecyc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail = 0;
  int          exp_done_cyc = -1;
  bit          prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic [4:0]  prev_addr;
  logic [4:0]  prev_rd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit rdy(input int mode, input int j);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (j % 5 == 0) || (j % 5 == 3);
    return 1'($urandom_range(0, 1));
  endfunction

  // Monitor: a word is accepted at the next rising edge when valid && ready && !abort.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (prev_stall) begin
        chk("stall_valid", bus.out_valid, 1'b1);
        chk("stall_data", bus.out_data, prev_data);
        chk("stall_addr", bus.out_addr, prev_addr);
        chk("stall_rdaddr", bus.rdAddr, prev_rd);
      end
      if (bus.done || cyc == exp_done_cyc)
        chk("done_timing", bus.done, cyc == exp_done_cyc);
      if (bus.out_valid && bus.out_ready && !bus.abort) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word actual addr=%0d required none", bus.out_addr);
        end else begin
          mon_e = q.pop_front();
          chk("word_addr", bus.out_addr, mon_e.addr);
          chk("word_data", bus.out_data, mon_e.data);
          if (mon_e.ecyc >= 0) chk("word_cycle", cyc, mon_e.ecyc);
          if (mon_e.last) exp_done_cyc = cyc + 1;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready && !bus.abort;
      prev_data  = bus.out_data;
      prev_addr  = bus.out_addr;
      prev_rd    = bus.rdAddr;
    end
  end

  // kind: 0 none, 1 extra start, 2 abort, 3 write R5 with evd, 4 async reset; evc = cycle of event.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int mode,
                          input int kind, input int evc, input logic [63:0] evd);
    logic [4:0] span;
    logic [4:0] a;
    exp_t       e;
    int         n;
    int         s;
    bit         seen;
    span = l - f;
    n = int'(span) + 1;
    s = cyc;
    for (int k = 0; k < n; k++) begin
      a      = f + 5'(k);
      e.addr = a;
      e.data = regs[a];
      e.last = (k == n - 1);
      e.ecyc = (mode == 0) ? s + 2 + k : -1;
      q.push_back(e);
    end
    bus.start      = 1'b1;
    bus.first_addr = f;
    bus.last_addr  = l;
    bus.out_ready  = 1'b1;
    seen = 1'b0;
    for (int j = 1; j <= 4 * n + 20; j++) begin
      @(posedge clk);
      #1;
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      wr_en         = 1'b0;
      bus.out_ready = rdy(mode, j);
      if (j == 1) begin
        chk("busy_cycle1", bus.busy, 1'b1);
        chk("rdaddr_cycle1", bus.rdAddr, f);
      end
      if (kind == 2 && j == evc + 1) begin
        chk("abort_valid", bus.out_valid, 1'b0);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_done", bus.done, 1'b0);
        q.delete();
        return;
      end
      if (bus.done) begin
        if (mode == 0) chk("done_cycle", cyc, s + n + 2);
        chk("done_busy", bus.busy, 1'b0);
        chk("done_valid", bus.out_valid, 1'b0);
        chk("done_drained", q.size(), 0);
        seen = 1'b1;
        break;
      end
      if (j == evc) begin
        case (kind)
          1: begin
            bus.start      = 1'b1;
            bus.first_addr = f + 5'd10;
            bus.last_addr  = f + 5'd12;
          end
          2: bus.abort = 1'b1;
          3: begin
            wr_en   = 1'b1;
            wr_addr = 5'd5;
            wr_data = evd;
          end
          4: begin
            @(negedge clk);
            #2;
            reset = 1'b1;
            #1;
            chk("rst_valid", bus.out_valid, 1'b0);
            chk("rst_busy", bus.busy, 1'b0);
            chk("rst_done", bus.done, 1'b0);
            chk("rst_data", bus.out_data, 64'd0);
            chk("rst_addr", bus.out_addr, 5'd0);
            chk("rst_rdaddr", bus.rdAddr, 5'd0);
            q.delete();
            prev_stall   = 1'b0;
            exp_done_cyc = -1;
            @(posedge clk);
            #2;
            reset = 1'b0;
            return;
          end
          default: ;
        endcase
      end
    end
    if (!seen) begin
      chk("done_timeout", 1'b0, 1'b1);
      q.delete();
    end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.first_addr = '0;
    bus.last_addr  = '0;
    bus.out_ready  = 1'b1;
    #1 reset = 1'b1;
    #2;
    chk("reset_rdaddr", bus.rdAddr, 5'd0);
    chk("reset_data", bus.out_data, 64'd0);
    chk("reset_addr", bus.out_addr, 5'd0);
    chk("reset_valid", bus.out_valid, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int a = 0; a < 32; a++) begin
      wr_en   = 1'b1;
      wr_addr = 5'(a);
      wr_data = {$urandom, $urandom};
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
    @(posedge clk);
    #1;

    run_dump(5'd0, 5'd31, 0, 0, 0, 64'd0);
    run_dump(5'd30, 5'd1, 0, 0, 0, 64'd0);
    run_dump(5'd7, 5'd7, 0, 0, 0, 64'd0);
    run_dump(5'd4, 5'd9, 1, 0, 0, 64'd0);
    run_dump(5'd0, 5'd31, 0, 1, 3, 64'd0);
    run_dump(5'd0, 5'd31, 0, 2, 5, 64'd0);
    run_dump(5'd2, 5'd6, 0, 0, 0, 64'd0);
    run_dump(5'd0, 5'd31, 0, 4, 6, 64'd0);
    run_dump(5'd0, 5'd0, 0, 0, 0, 64'd0);
    run_dump(5'd3, 5'd7, 0, 3, 3, 64'hDEAD_BEEF_0123_4567);
    run_dump(5'd3, 5'd7, 0, 0, 0, 64'd0);
    for (int i = 0; i < 8; i++)
      run_dump(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 2, 0, 0, 64'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    n_fail++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
